median_frame_scheduler: RTL and testbench
=========================================

Name: median_frame_scheduler

Overview:
- Sequences the binary median-window filter over ping-pong frame buffers.
- A frame loader writes bank A while the filter scans bank B; the scheduler tracks bank ownership, drives the filter's level-sensitive start, waits for the final window count to settle, and returns the active-window count through a valid/ready result port.
- Sits between the frame loader, the filter core and the host/result logic.

Parameters:
COUNT_W, 13, width of the filter's active-window count
SETTLE_CYCLES, 2, cycles from filterDone seen high to a stable activeWindowsIn
MAX_FRAME_CYCLES, 200000, watchdog limit for one filter run (RUN state)
WDOG_W, 18, watchdog counter width; must hold MAX_FRAME_CYCLES

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
loadEnable  out  1  loader may write bank loadBank
loadBank  out  1  bank the loader targets
frameLoadDone  in  1  one-cycle pulse: loader finished a frame; ignored unless loadEnable=1
filterStart  out  1  level start to the filter; low clears the filter's counters
filterBank  out  1  bank the filter reads (muxes the memory address/data)
filterDone  in  1  filter full-image-done flag
activeWindowsIn  in  COUNT_W  filter active-window count
resultCount  out  COUNT_W  captured count for the completed frame
resultValid  out  1  resultCount valid; held until accepted
resultReady  in  1  consumer accepts on resultValid & resultReady
bankFull  out  2  per-bank FULL-or-FILTERING flag (status)
watchdogErr  out  1  sticky; set on a filter timeout

Behaviour:
- Reset: every bank EMPTY; loadBank=0; loadEnable=1; filterStart=0; filterBank=0; resultCount=0; resultValid=0; watchdogErr=0; FSM=IDLE; watchdog=0. Applies mid-frame and overrides every other event in that cycle.
- Bank states: EMPTY -> FULL on frameLoadDone to loadBank; FULL -> FILTERING on IDLE->ARM; FILTERING -> EMPTY on CAPTURE or ABORT.
- Loader side: loadEnable=1 while bank[loadBank] is EMPTY.
  - After frameLoadDone, loadBank toggles in the next cycle.
  - If the new bank is not EMPTY, loadEnable=0 until it frees. loadEnable rises the cycle after the bank frees.
- Filter FSM:
  - IDLE: wait for a FULL bank and resultValid=0. If both banks are FULL, take the older one (first-loaded flag). Latch filterBank, then go to ARM.
  - ARM: filterStart=0 for exactly 1 cycle so the filter's counters clear. Go to RUN.
  - RUN: filterStart=1; the watchdog increments each cycle.
    - filterDone=1 -> SETTLE.
    - Watchdog == MAX_FRAME_CYCLES-1 -> ABORT.
  - SETTLE: filterStart stays 1 for SETTLE_CYCLES cycles, so the last window's increment lands. Then go to CAPTURE.
  - CAPTURE (1 cycle):
    - resultCount <= activeWindowsIn; resultValid <= 1.
    - filterStart <= 0; bank[filterBank] -> EMPTY; watchdog=0.
    - Go to IDLE.
  - ABORT (1 cycle): filterStart <= 0; bank -> EMPTY; watchdogErr <= 1; no result is produced. Go to IDLE.
- Result port: resultValid stays high, with resultCount stable, until the handshake. It clears the cycle after the handshake. IDLE blocks while resultValid=1, which gives back-pressure; the loader stalls once both banks fill.
- Latency: filterDone high at cycle t gives resultValid=1 at t+SETTLE_CYCLES+1.
- Simultaneous events:
  - A bank freed by CAPTURE/ABORT and a frameLoadDone on the other bank in the same cycle: both take effect.
  - A freed bank equal to a stalled loadBank: loadEnable=1 in the next cycle.
  - frameLoadDone while loadEnable=0: ignored, no state change.
- filterDone outside RUN: ignored.
- Arithmetic: the watchdog saturates at the compare point and is never allowed to wrap.

Decomposition:
- Package median_ctrl_pkg holds:
  - the bank-state enum (EMPTY, FULL, FILTERING);
  - the FSM enum (IDLE, ARM, RUN, SETTLE, CAPTURE, ABORT);
  - IMAGEWIDTH=240, IMAGEHEIGHT=180, COUNT_W;
  - the default MAX_FRAME_CYCLES.
- One sub-module, median_bank_tracker, holds the two bank states, the loadBank/loadEnable logic and the oldest-full select. The FSM stays in the top.

Test Plan:
- Single frame: frameLoadDone on bank0 -> ARM 1 cycle with filterStart=0, RUN with filterBank=0. Then filterDone with activeWindowsIn=37 at t -> resultValid=1, resultCount=37 at t+3, bank0 EMPTY.
- Ping-pong: load bank0 then bank1 while bank0 filters -> loadBank toggles 0->1, and loadEnable=0 after the second load. After CAPTURE, filterBank=1 starts once the result is taken.
- Back-pressure: hold resultReady=0 with both banks FULL -> FSM stays IDLE, loadEnable=0, resultCount is unchanged. resultReady=1 for 1 cycle -> resultValid drops and the next ARM follows.
- Watchdog: MAX_FRAME_CYCLES=50, filterDone held low -> ABORT at RUN cycle 50, watchdogErr=1, resultValid stays 0, bank freed.
- Reset mid-RUN with banks FULL/FILTERING -> next cycle all outputs at reset values, and frameLoadDone in the reset cycle is ignored.
- Ignored inputs: filterDone pulse in IDLE -> no result. frameLoadDone while loadEnable=0 -> bankFull is unchanged.

Source files
------------

// File: rtl/median_ctrl_pkg.sv
// Shared types and constants for the median filter frame scheduler.
package median_ctrl_pkg;

  localparam int IMAGEWIDTH               = 240;
  localparam int IMAGEHEIGHT              = 180;
  localparam int COUNT_W                  = 13;
  localparam int DEF_MAX_FRAME_CYCLES     = 200000;

  // Ownership of one ping-pong frame bank.
  typedef enum logic [1:0] {
    BANK_EMPTY,
    BANK_FULL,
    BANK_FILTERING
  } bank_state_t;

  // Filter sequencing states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_RUN,
    ST_SETTLE,
    ST_CAPTURE,
    ST_ABORT
  } filter_state_t;

  // Next ownership of one bank. The three events never target the same bank
  // in one cycle (a load needs EMPTY, a claim needs FULL, a free needs
  // FILTERING), so the priority order only documents intent.
  function automatic bank_state_t bank_next(bank_state_t cur, logic load,
                                            logic claim, logic free);
    bank_state_t nxt;
    nxt = cur;
    if (load) begin
      nxt = BANK_FULL;
    end else if (claim) begin
      nxt = BANK_FILTERING;
    end else if (free) begin
      nxt = BANK_EMPTY;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/median_bank_tracker.sv
// Tracks ownership of the two frame banks, steers the loader and picks the
// oldest full bank for the filter.
module median_bank_tracker
  import median_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_load_done,
  input  logic       claim,
  input  logic       claim_bank,
  input  logic       free_en,
  input  logic       free_bank,
  output logic       load_enable,
  output logic       load_bank,
  output logic [1:0] bank_full,
  output logic       full_avail,
  output logic       oldest_bank
);

  bank_state_t bank_q [2];
  logic        load_bank_q;
  logic        last_loaded_q;
  logic        load_fire;
  logic        full0;
  logic        full1;

  // A load is only accepted while the targeted bank is free; pulses at other
  // times are dropped without any state change.
  assign load_enable = (bank_q[load_bank_q] == BANK_EMPTY);
  assign load_fire   = frame_load_done & load_enable;
  assign load_bank   = load_bank_q;

  assign full0      = (bank_q[0] == BANK_FULL);
  assign full1      = (bank_q[1] == BANK_FULL);
  assign full_avail = full0 | full1;
  // With both banks waiting, the one not loaded most recently is older.
  assign oldest_bank = (full0 && full1) ? ~last_loaded_q : full1;
  assign bank_full   = {bank_q[1] != BANK_EMPTY, bank_q[0] != BANK_EMPTY};

  // Bank ownership and loader pointer update.
  always_ff @(posedge clk) begin
    if (reset) begin
      bank_q[0]     <= BANK_EMPTY;
      bank_q[1]     <= BANK_EMPTY;
      load_bank_q   <= 1'b0;
      last_loaded_q <= 1'b0;
    end else begin
      bank_q[0] <= bank_next(bank_q[0], load_fire && !load_bank_q,
                             claim && !claim_bank, free_en && !free_bank);
      bank_q[1] <= bank_next(bank_q[1], load_fire && load_bank_q,
                             claim && claim_bank, free_en && free_bank);
      if (load_fire) begin
        load_bank_q   <= ~load_bank_q;
        last_loaded_q <= load_bank_q;
      end
    end
  end

endmodule

// File: rtl/median_frame_scheduler.sv
// Sequences the median-window filter over ping-pong frame banks and returns
// each frame's active-window count through a valid/ready result port.
//
// Result handshake: resultValid rises with resultCount and both stay stable
// until a cycle where resultValid & resultReady are both high; resultValid
// is low from the following cycle. No new frame is armed while a result is
// pending, which is what back-pressures the loader.
module median_frame_scheduler #(
  parameter int COUNT_W          = median_ctrl_pkg::COUNT_W,
  parameter int SETTLE_CYCLES    = 2,
  parameter int MAX_FRAME_CYCLES = median_ctrl_pkg::DEF_MAX_FRAME_CYCLES,
  parameter int WDOG_W           = 18
) (
  input  logic                            clk,
  input  logic                            reset,
  output logic                            loadEnable,
  output logic                            loadBank,
  input  logic                            frameLoadDone,
  output logic                            filterStart,
  output logic                            filterBank,
  input  logic                            filterDone,
  input  logic [COUNT_W-1:0]              activeWindowsIn,
  output logic [COUNT_W-1:0]              resultCount,
  output logic                            resultValid,
  input  logic                            resultReady,
  output logic [1:0]                      bankFull,
  output logic                            watchdogErr,
  output median_ctrl_pkg::filter_state_t  debugState
);

  import median_ctrl_pkg::*;

  localparam int                SETTLE_W    = $clog2(SETTLE_CYCLES + 1);
  // SETTLE lasts SETTLE_CYCLES-1 cycles so CAPTURE samples the count exactly
  // SETTLE_CYCLES cycles after filterDone was seen.
  localparam logic [SETTLE_W-1:0] SETTLE_LAST =
    SETTLE_W'((SETTLE_CYCLES > 1) ? SETTLE_CYCLES - 2 : 0);
  localparam logic [WDOG_W-1:0]   WDOG_LIMIT  = WDOG_W'(MAX_FRAME_CYCLES - 1);

  filter_state_t         state_q;
  filter_state_t         state_d;
  logic                  filter_bank_q;
  logic [WDOG_W-1:0]     wdog_q;
  logic [SETTLE_W-1:0]   settle_q;
  logic                  claim;
  logic                  free_en;
  logic                  capture;
  logic                  abort;
  logic                  full_avail;
  logic                  oldest_bank;

  median_bank_tracker u_tracker (
    .clk             (clk),
    .reset           (reset),
    .frame_load_done (frameLoadDone),
    .claim           (claim),
    .claim_bank      (oldest_bank),
    .free_en         (free_en),
    .free_bank       (filter_bank_q),
    .load_enable     (loadEnable),
    .load_bank       (loadBank),
    .bank_full       (bankFull),
    .full_avail      (full_avail),
    .oldest_bank     (oldest_bank)
  );

  // Start is held through CAPTURE so the count is still valid when sampled;
  // it drops the cycle after, clearing the filter's counters.
  assign filterStart = (state_q == ST_RUN) || (state_q == ST_SETTLE) ||
                       (state_q == ST_CAPTURE);
  assign filterBank  = filter_bank_q;
  assign debugState  = state_q;

  // Next-state and per-state strobes.
  always_comb begin
    state_d = state_q;
    claim   = 1'b0;
    free_en = 1'b0;
    capture = 1'b0;
    abort   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (full_avail && !resultValid) begin
          claim   = 1'b1;
          state_d = ST_ARM;
        end
      end
      ST_ARM: state_d = ST_RUN;
      ST_RUN: begin
        if (filterDone) begin
          if (SETTLE_CYCLES > 1) begin
            state_d = ST_SETTLE;
          end else begin
            state_d = ST_CAPTURE;
          end
        end else if (wdog_q == WDOG_LIMIT) begin
          state_d = ST_ABORT;
        end
      end
      ST_SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        capture = 1'b1;
        free_en = 1'b1;
        state_d = ST_IDLE;
      end
      ST_ABORT: begin
        abort   = 1'b1;
        free_en = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register, watchdog, settle timer and result port.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      filter_bank_q <= 1'b0;
      wdog_q        <= '0;
      settle_q      <= '0;
      resultCount   <= '0;
      resultValid   <= 1'b0;
      watchdogErr   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (claim) begin
        filter_bank_q <= oldest_bank;
      end
      // Watchdog counts RUN cycles only and saturates at the abort point.
      if (state_q == ST_RUN) begin
        if (wdog_q != WDOG_LIMIT) begin
          wdog_q <= wdog_q + WDOG_W'(1);
        end
      end else begin
        wdog_q <= '0;
      end
      if (state_q == ST_SETTLE) begin
        settle_q <= settle_q + SETTLE_W'(1);
      end else begin
        settle_q <= '0;
      end
      if (capture) begin
        resultCount <= activeWindowsIn;
        resultValid <= 1'b1;
      end else if (resultValid && resultReady) begin
        resultValid <= 1'b0;
      end
      if (abort) begin
        watchdogErr <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_median_frame_scheduler.sv
// Bench for the median frame scheduler: directed scenarios followed by a
// randomized run against a queue-based reference model.
module tb_median_frame_scheduler;
  import median_ctrl_pkg::*;

  localparam int CW     = 13;
  localparam int SETTLE = 2;
  localparam int MAXC   = 50;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          frameLoadDone = 1'b0;
  logic          filterDone = 1'b0;
  logic [CW-1:0] activeWindowsIn = '0;
  logic          resultReady = 1'b0;
  logic          loadEnable, loadBank, filterStart, filterBank;
  logic          resultValid, watchdogErr;
  logic [CW-1:0] resultCount;
  logic [1:0]    bankFull;
  filter_state_t debugState;

  int n_tests = 0;
  int n_fail  = 0;

  median_frame_scheduler #(
    .COUNT_W(CW), .SETTLE_CYCLES(SETTLE), .MAX_FRAME_CYCLES(MAXC), .WDOG_W(18)
  ) dut (
    .clk(clk), .reset(reset), .loadEnable(loadEnable), .loadBank(loadBank),
    .frameLoadDone(frameLoadDone), .filterStart(filterStart),
    .filterBank(filterBank), .filterDone(filterDone),
    .activeWindowsIn(activeWindowsIn), .resultCount(resultCount),
    .resultValid(resultValid), .resultReady(resultReady),
    .bankFull(bankFull), .watchdogErr(watchdogErr), .debugState(debugState)
  );

  // ---------------- reference model ----------------
  // Bank contents: 0 empty, 1 loaded and waiting, 2 being filtered.
  // full_q lists waiting banks in load order, so the oldest is at the front.
  localparam int P_IDLE = 0, P_ARM = 1, P_RUN = 2, P_SETTLE = 3,
                 P_CAPTURE = 4, P_ABORT = 5;
  int            m_bank [2];
  int            full_q [$];
  int            m_lb, m_phase, m_fb, m_run, m_settle;
  bit            m_rv, m_err;
  logic [CW-1:0] m_rc;
  logic [CW-1:0] exp_q [$];

  task automatic model_reset();
    m_bank[0] = 0; m_bank[1] = 0; full_q.delete(); exp_q.delete();
    m_lb = 0; m_phase = P_IDLE; m_fb = 0; m_run = 0; m_settle = 0;
    m_rv = 1'b0; m_err = 1'b0; m_rc = '0;
  endtask

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_step();
    bit ld;
    bit rv_old;
    if (reset) begin
      model_reset();
      return;
    end
    rv_old = m_rv;
    ld = frameLoadDone && (m_bank[m_lb] == 0);
    if (m_rv && resultReady) m_rv = 1'b0;
    case (m_phase)
      P_IDLE: if (full_q.size() > 0 && !rv_old) begin
        m_fb = full_q.pop_front(); m_bank[m_fb] = 2; m_phase = P_ARM;
      end
      P_ARM: begin m_run = 0; m_phase = P_RUN; end
      P_RUN: begin
        m_run++;
        if (filterDone) begin
          m_settle = SETTLE - 1;
          m_phase = (m_settle == 0) ? P_CAPTURE : P_SETTLE;
        end else if (m_run == MAXC) begin
          m_phase = P_ABORT;
        end
      end
      P_SETTLE: begin m_settle--; if (m_settle == 0) m_phase = P_CAPTURE; end
      P_CAPTURE: begin
        m_rc = activeWindowsIn; m_rv = 1'b1; exp_q.push_back(activeWindowsIn);
        m_bank[m_fb] = 0; m_phase = P_IDLE;
      end
      P_ABORT: begin m_err = 1'b1; m_bank[m_fb] = 0; m_phase = P_IDLE; end
      default: m_phase = P_IDLE;
    endcase
    if (ld) begin
      m_bank[m_lb] = 1; full_q.push_back(m_lb); m_lb = 1 - m_lb;
    end
  endtask

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1; tick(); tick();
    n_tests++; if (loadEnable !== 1'b1) begin n_fail++; $display("FAIL reset_loadEnable got=%b want=1", loadEnable); end
    n_tests++; if (loadBank !== 1'b0) begin n_fail++; $display("FAIL reset_loadBank got=%b want=0", loadBank); end
    n_tests++; if (filterStart !== 1'b0) begin n_fail++; $display("FAIL reset_filterStart got=%b want=0", filterStart); end
    n_tests++; if (resultValid !== 1'b0 || resultCount !== '0) begin n_fail++; $display("FAIL reset_result got=%b/%0d want=0/0", resultValid, resultCount); end
    n_tests++; if (bankFull !== 2'b00 || watchdogErr !== 1'b0) begin n_fail++; $display("FAIL reset_status got=%b/%b want=00/0", bankFull, watchdogErr); end
    n_tests++; if (debugState !== ST_IDLE) begin n_fail++; $display("FAIL reset_state got=%0d want=%0d", debugState, ST_IDLE); end
    reset = 1'b0;
  endtask

  task automatic test_single_frame();
    frameLoadDone = 1'b1; tick(); frameLoadDone = 1'b0;
    n_tests++; if (bankFull !== 2'b01 || loadBank !== 1'b1) begin n_fail++; $display("FAIL single_load got=%b/%b want=01/1", bankFull, loadBank); end
    tick();
    n_tests++; if (debugState !== ST_ARM || filterStart !== 1'b0 || filterBank !== 1'b0) begin n_fail++; $display("FAIL single_arm got=%0d/%b/%b want=%0d/0/0", debugState, filterStart, filterBank, ST_ARM); end
    tick();
    n_tests++; if (debugState !== ST_RUN || filterStart !== 1'b1 || filterBank !== 1'b0) begin n_fail++; $display("FAIL single_run got=%0d/%b/%b want=%0d/1/0", debugState, filterStart, filterBank, ST_RUN); end
    repeat (4) tick();
    filterDone = 1'b1; activeWindowsIn = 13'd37; tick(); filterDone = 1'b0;
    tick();
    n_tests++; if (resultValid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid got=%b want=0", resultValid); end
    tick();
    n_tests++; if (resultValid !== 1'b1 || resultCount !== 13'd37) begin n_fail++; $display("FAIL single_result got=%b/%0d want=1/37", resultValid, resultCount); end
    n_tests++; if (bankFull !== 2'b00) begin n_fail++; $display("FAIL single_freed got=%b want=00", bankFull); end
    resultReady = 1'b1; tick(); resultReady = 1'b0;
    n_tests++; if (resultValid !== 1'b0) begin n_fail++; $display("FAIL single_accept got=%b want=0", resultValid); end
  endtask

  task automatic test_ping_pong();
    reset = 1'b1; tick(); reset = 1'b0;
    frameLoadDone = 1'b1; tick(); frameLoadDone = 1'b0; tick();
    n_tests++; if (loadBank !== 1'b1 || loadEnable !== 1'b1) begin n_fail++; $display("FAIL pp_first got=%b/%b want=1/1", loadBank, loadEnable); end
    frameLoadDone = 1'b1; tick(); frameLoadDone = 1'b0;
    n_tests++; if (loadBank !== 1'b0 || loadEnable !== 1'b0 || bankFull !== 2'b11) begin n_fail++; $display("FAIL pp_second got=%b/%b/%b want=0/0/11", loadBank, loadEnable, bankFull); end
    filterDone = 1'b1; activeWindowsIn = 13'd100; tick(); filterDone = 1'b0; tick(); tick();
    n_tests++; if (resultValid !== 1'b1 || loadEnable !== 1'b1) begin n_fail++; $display("FAIL pp_capture got=%b/%b want=1/1", resultValid, loadEnable); end
    tick();
    n_tests++; if (debugState !== ST_IDLE || filterBank !== 1'b0) begin n_fail++; $display("FAIL pp_blocked got=%0d/%b want=%0d/0", debugState, filterBank, ST_IDLE); end
    resultReady = 1'b1; tick(); resultReady = 1'b0; tick();
    n_tests++; if (debugState !== ST_ARM || filterBank !== 1'b1) begin n_fail++; $display("FAIL pp_next got=%0d/%b want=%0d/1", debugState, filterBank, ST_ARM); end
  endtask

  task automatic test_back_pressure();
    reset = 1'b1; tick(); reset = 1'b0;
    frameLoadDone = 1'b1; tick(); frameLoadDone = 1'b0; tick();
    frameLoadDone = 1'b1; tick(); frameLoadDone = 1'b0;
    filterDone = 1'b1; activeWindowsIn = 13'd55; tick(); filterDone = 1'b0; tick(); tick();
    frameLoadDone = 1'b1; tick(); frameLoadDone = 1'b0;
    n_tests++; if (bankFull !== 2'b11 || loadEnable !== 1'b0) begin n_fail++; $display("FAIL bp_full got=%b/%b want=11/0", bankFull, loadEnable); end
    for (int i = 0; i < 5; i++) begin
      activeWindowsIn = CW'($urandom_range(0, 8191));
      frameLoadDone = 1'b1; tick(); frameLoadDone = 1'b0;
      n_tests++; if (debugState !== ST_IDLE || loadEnable !== 1'b0) begin n_fail++; $display("FAIL bp_stall got=%0d/%b want=%0d/0", debugState, loadEnable, ST_IDLE); end
      n_tests++; if (resultValid !== 1'b1 || resultCount !== 13'd55) begin n_fail++; $display("FAIL bp_hold got=%b/%0d want=1/55", resultValid, resultCount); end
      n_tests++; if (bankFull !== 2'b11 || loadBank !== 1'b1) begin n_fail++; $display("FAIL ignored_load got=%b/%b want=11/1", bankFull, loadBank); end
    end
    resultReady = 1'b1; tick(); resultReady = 1'b0;
    n_tests++; if (resultValid !== 1'b0 || debugState !== ST_IDLE) begin n_fail++; $display("FAIL bp_accept got=%b/%0d want=0/%0d", resultValid, debugState, ST_IDLE); end
    tick();
    n_tests++; if (debugState !== ST_ARM || filterBank !== 1'b1) begin n_fail++; $display("FAIL bp_oldest got=%0d/%b want=%0d/1", debugState, filterBank, ST_ARM); end
    tick();
  endtask

  task automatic test_watchdog();
    int run_cycles = 0;
    while (debugState == ST_RUN && run_cycles < 200) begin
      run_cycles++;
      tick();
    end
    n_tests++; if (run_cycles != MAXC || debugState !== ST_ABORT) begin n_fail++; $display("FAIL wdog_timeout got=%0d/%0d want=%0d/%0d", run_cycles, debugState, MAXC, ST_ABORT); end
    tick();
    n_tests++; if (watchdogErr !== 1'b1 || resultValid !== 1'b0) begin n_fail++; $display("FAIL wdog_err got=%b/%b want=1/0", watchdogErr, resultValid); end
    n_tests++; if (bankFull !== 2'b01 || debugState !== ST_IDLE) begin n_fail++; $display("FAIL wdog_free got=%b/%0d want=01/%0d", bankFull, debugState, ST_IDLE); end
    tick(); tick();
    n_tests++; if (debugState !== ST_RUN || filterBank !== 1'b0 || watchdogErr !== 1'b1) begin n_fail++; $display("FAIL wdog_sticky got=%0d/%b/%b want=%0d/0/1", debugState, filterBank, watchdogErr, ST_RUN); end
  endtask

  task automatic test_reset_mid_run();
    frameLoadDone = 1'b1; tick(); frameLoadDone = 1'b0;
    n_tests++; if (bankFull !== 2'b11 || debugState !== ST_RUN) begin n_fail++; $display("FAIL mid_setup got=%b/%0d want=11/%0d", bankFull, debugState, ST_RUN); end
    reset = 1'b1; frameLoadDone = 1'b1; tick(); reset = 1'b0; frameLoadDone = 1'b0;
    n_tests++; if (loadEnable !== 1'b1 || loadBank !== 1'b0 || bankFull !== 2'b00) begin n_fail++; $display("FAIL mid_loader got=%b/%b/%b want=1/0/00", loadEnable, loadBank, bankFull); end
    n_tests++; if (filterStart !== 1'b0 || filterBank !== 1'b0 || debugState !== ST_IDLE) begin n_fail++; $display("FAIL mid_filter got=%b/%b/%0d want=0/0/%0d", filterStart, filterBank, debugState, ST_IDLE); end
    n_tests++; if (resultValid !== 1'b0 || resultCount !== '0 || watchdogErr !== 1'b0) begin n_fail++; $display("FAIL mid_result got=%b/%0d/%b want=0/0/0", resultValid, resultCount, watchdogErr); end
    tick();
    n_tests++; if (bankFull !== 2'b00 || debugState !== ST_IDLE) begin n_fail++; $display("FAIL mid_load_dropped got=%b/%0d want=00/%0d", bankFull, debugState, ST_IDLE); end
  endtask

  task automatic test_ignored_inputs();
    filterDone = 1'b1; activeWindowsIn = 13'd9; tick(); filterDone = 1'b0; tick(); tick(); tick();
    n_tests++; if (resultValid !== 1'b0 || debugState !== ST_IDLE || filterStart !== 1'b0) begin n_fail++; $display("FAIL ignored_done got=%b/%0d/%b want=0/%0d/0", resultValid, debugState, filterStart, ST_IDLE); end
  endtask

  task automatic test_random();
    logic       exp_le, exp_fs;
    logic [1:0] exp_bf;
    int         done_pct;
    reset = 1'b1; tick(); reset = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 400 == 0) done_pct = (cyc % 800 == 0) ? 15 : 2;
      reset           = ($urandom_range(0, 299) == 0);
      frameLoadDone   = ($urandom_range(0, 3) == 0);
      filterDone      = ($urandom_range(0, 99) < done_pct);
      activeWindowsIn = CW'($urandom_range(0, 8191));
      resultReady     = ($urandom_range(0, 2) == 0);
      if (!reset && resultValid && resultReady) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL rnd_unexpected_result got=%0d want=none", resultCount);
        end else begin
          logic [CW-1:0] e;
          e = exp_q.pop_front();
          if (resultCount !== e) begin n_fail++; $display("FAIL rnd_scoreboard got=%0d want=%0d", resultCount, e); end
        end
      end
      tick();
      exp_le = (m_bank[m_lb] == 0);
      exp_fs = (m_phase == P_RUN || m_phase == P_SETTLE || m_phase == P_CAPTURE);
      exp_bf = {m_bank[1] != 0, m_bank[0] != 0};
      n_tests++; if (loadEnable !== exp_le || loadBank !== 1'(m_lb)) begin n_fail++; $display("FAIL rnd_loader cyc=%0d got=%b/%b want=%b/%0d", cyc, loadEnable, loadBank, exp_le, m_lb); end
      n_tests++; if (filterStart !== exp_fs || filterBank !== 1'(m_fb)) begin n_fail++; $display("FAIL rnd_filter cyc=%0d got=%b/%b want=%b/%0d", cyc, filterStart, filterBank, exp_fs, m_fb); end
      n_tests++; if (resultValid !== m_rv || resultCount !== m_rc) begin n_fail++; $display("FAIL rnd_result cyc=%0d got=%b/%0d want=%b/%0d", cyc, resultValid, resultCount, m_rv, m_rc); end
      n_tests++; if (bankFull !== exp_bf || watchdogErr !== m_err) begin n_fail++; $display("FAIL rnd_status cyc=%0d got=%b/%b want=%b/%b", cyc, bankFull, watchdogErr, exp_bf, m_err); end
    end
    reset = 1'b0; frameLoadDone = 1'b0; filterDone = 1'b0; resultReady = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    model_reset();
    test_reset();
    test_single_frame();
    test_ping_pong();
    test_back_pressure();
    test_watchdog();
    test_reset_mid_run();
    test_ignored_inputs();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

endmodule
